// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester and memory-side signals.
// slave  : the arbiter's view (requests and memory responses in).
// master : the view of whatever surrounds the arbiter (core paths + memory).
interface mem_arbiter_if #(
  parameter int NBITS = 8
);
  // fetch requester
  logic             i_req;
  logic [NBITS-1:0] i_addr;
  logic [NBITS-1:0] i_rdata;
  logic             i_done;
  logic             i_busy;
  // load/store requester
  logic             d_req;
  logic             d_we;
  logic [NBITS-1:0] d_addr;
  logic [NBITS-1:0] d_wdata;
  logic [NBITS-1:0] d_rdata;
  logic             d_done;
  logic             d_busy;
  // memory side
  logic             m_req;
  logic             m_we;
  logic [NBITS-1:0] m_addr;
  logic [NBITS-1:0] m_wdata;
  logic [NBITS-1:0] m_rdata;
  logic             m_ready;
  logic             err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_done, i_busy, d_rdata, d_done, d_busy,
           m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_done, i_busy, d_rdata, d_done, d_busy,
           m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch
// path and the load/store path. Every transaction walks IDLE -> MEM -> DONE,
// so a request still held high during its done cycle is never issued twice.
module mem_arbiter #(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t           state, state_nxt;
  logic             grant_i, grant_d, mem_ok, mem_to;
  logic             owner_d;   // 1: current transaction belongs to load/store
  logic             last_d;    // 1: load/store won the previous grant
  logic [CW-1:0]    cnt;

  logic             m_req_q, m_we_q, i_done_q, d_done_q, err_q;
  logic [NBITS-1:0] m_addr_q, m_wdata_q, i_rdata_q, d_rdata_q;

  // Next-state and grant decode; ties go to whoever did not win last time.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    mem_ok    = 1'b0;
    mem_to    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && (!bus.i_req || !last_d)) begin
          grant_d   = 1'b1;
          state_nxt = MEM;
        end else if (bus.i_req) begin
          grant_i   = 1'b1;
          state_nxt = MEM;
        end
      end
      MEM: begin
        // a ready in the final allowed cycle still counts as success
        if (bus.m_ready) begin
          mem_ok    = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          mem_to    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side registers, wait counter, completion pulses and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      cnt       <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
      if (grant_i || grant_d) begin
        m_req_q   <= 1'b1;
        m_we_q    <= grant_d & bus.d_we;
        m_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
        m_wdata_q <= grant_d ? bus.d_wdata : '0;
        owner_d   <= grant_d;
        last_d    <= grant_d;
        cnt       <= '0;
      end
      if (state == MEM) begin
        if (cnt != '1) cnt <= cnt + CW'(1);
        if (mem_ok || mem_to) begin
          m_req_q  <= 1'b0;
          m_we_q   <= 1'b0;
          i_done_q <= ~owner_d;
          d_done_q <= owner_d;
          err_q    <= mem_to;
        end
        // stores and timeouts leave the owner's read data untouched
        if (mem_ok && !m_we_q) begin
          if (owner_d) d_rdata_q <= bus.m_rdata;
          else         i_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.err     = err_q;
  assign bus.i_busy  = bus.i_req & ~i_done_q;
  assign bus.d_busy  = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour,
// then hand-written sequences for reset abort, contention, timeout, early drop.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset;

  mem_arbiter_if #(.NBITS(8)) bus ();
  mem_arbiter #(.NBITS(8), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, ireq;
    logic [7:0] iaddr;
    logic       dreq, dwe;
    logic [7:0] daddr, dwdata;
    logic       mrdy;
    logic [7:0] mrdata;
    logic       e_mreq, e_mwe;
    logic [7:0] e_maddr, e_mwdata, e_irdata, e_drdata;
    logic       e_idone, e_ddone, e_err, e_ibusy, e_dbusy;
  } vec_t;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rst, input logic ireq, input logic [7:0] iaddr,
                     input logic dreq, input logic dwe, input logic [7:0] daddr,
                     input logic [7:0] dwdata, input logic mrdy, input logic [7:0] mrdata);
    reset       = rst;
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    bus.m_ready = mrdy;
    bus.m_rdata = mrdata;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  vec_t v[13];
  logic [7:0] order[$];
  int   n_idone, n_ddone, n_mreq;
  logic prev_mreq;
  bit   seen;

  initial begin
    //        rst ireq iaddr dreq dwe daddr  dwdata mrdy mrdata | mreq mwe maddr  mwdata irdata drdata idone ddone err ibusy dbusy
    v[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    v[1]  = '{0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 8'h00,  1, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0};
    v[2]  = '{0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 8'hA5,  0, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 1, 0, 0, 0, 0};
    v[3]  = '{0, 0, 8'h10, 0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 0, 0};
    v[4]  = '{0, 0, 8'h10, 1, 1, 8'h20, 8'h3C, 0, 8'h00,  1, 1, 8'h20, 8'h3C, 8'hA5, 8'h00, 0, 0, 0, 0, 1};
    v[5]  = '{0, 0, 8'h10, 1, 1, 8'h20, 8'h3C, 0, 8'h00,  1, 1, 8'h20, 8'h3C, 8'hA5, 8'h00, 0, 0, 0, 0, 1};
    v[6]  = '{0, 0, 8'h10, 1, 1, 8'h20, 8'h3C, 0, 8'h00,  1, 1, 8'h20, 8'h3C, 8'hA5, 8'h00, 0, 0, 0, 0, 1};
    v[7]  = '{0, 0, 8'h10, 1, 1, 8'h20, 8'h3C, 1, 8'h77,  0, 0, 8'h20, 8'h3C, 8'hA5, 8'h00, 0, 1, 0, 0, 0};
    v[8]  = '{0, 0, 8'h10, 0, 1, 8'h20, 8'h3C, 0, 8'h00,  0, 0, 8'h20, 8'h3C, 8'hA5, 8'h00, 0, 0, 0, 0, 0};
    // tie after a data grant goes to fetch; fetch clears m_wdata
    v[9]  = '{0, 1, 8'h11, 1, 0, 8'h21, 8'h00, 0, 8'h00,  1, 0, 8'h11, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 1, 1};
    v[10] = '{0, 1, 8'h11, 1, 0, 8'h21, 8'h00, 1, 8'h5C,  0, 0, 8'h11, 8'h00, 8'h5C, 8'h00, 1, 0, 0, 0, 1};
    // DONE does not sample requests
    v[11] = '{0, 1, 8'h11, 1, 0, 8'h21, 8'h00, 0, 8'h00,  0, 0, 8'h11, 8'h00, 8'h5C, 8'h00, 0, 0, 0, 1, 1};
    v[12] = '{0, 1, 8'h11, 1, 0, 8'h21, 8'h00, 0, 8'h00,  1, 0, 8'h21, 8'h00, 8'h5C, 8'h00, 0, 0, 0, 1, 1};

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    foreach (v[i]) begin
      drv(v[i].rst, v[i].ireq, v[i].iaddr, v[i].dreq, v[i].dwe, v[i].daddr,
          v[i].dwdata, v[i].mrdy, v[i].mrdata);
      step();
      chk($sformatf("row%0d m_req", i),   bus.m_req,   v[i].e_mreq);
      chk($sformatf("row%0d m_we", i),    bus.m_we,    v[i].e_mwe);
      chk($sformatf("row%0d m_addr", i),  bus.m_addr,  v[i].e_maddr);
      chk($sformatf("row%0d m_wdata", i), bus.m_wdata, v[i].e_mwdata);
      chk($sformatf("row%0d i_rdata", i), bus.i_rdata, v[i].e_irdata);
      chk($sformatf("row%0d d_rdata", i), bus.d_rdata, v[i].e_drdata);
      chk($sformatf("row%0d i_done", i),  bus.i_done,  v[i].e_idone);
      chk($sformatf("row%0d d_done", i),  bus.d_done,  v[i].e_ddone);
      chk($sformatf("row%0d err", i),     bus.err,     v[i].e_err);
      chk($sformatf("row%0d i_busy", i),  bus.i_busy,  v[i].e_ibusy);
      chk($sformatf("row%0d d_busy", i),  bus.d_busy,  v[i].e_dbusy);
    end

    // Reset while a data load sits in MEM with m_ready high: reset wins.
    drv(1, 1, 8'h11, 1, 0, 8'h21, 8'h00, 1, 8'hEE);
    step();
    chk("rst m_req",   bus.m_req,   1'b0);
    chk("rst m_addr",  bus.m_addr,  8'h00);
    chk("rst d_done",  bus.d_done,  1'b0);
    chk("rst err",     bus.err,     1'b0);
    chk("rst d_rdata", bus.d_rdata, 8'h00);
    chk("rst i_rdata", bus.i_rdata, 8'h00);

    // Contention after reset: D, I, D, I with zero-wait memory.
    drv(0, 1, 8'h30, 1, 0, 8'h40, 8'h00, 0, 8'h5A);
    step();
    chk("tie after reset m_req",  bus.m_req,  1'b1);
    chk("tie after reset m_addr", bus.m_addr, 8'h40);
    order.delete();
    order.push_back(bus.m_addr);
    n_idone = 0; n_ddone = 0; n_mreq = 1; prev_mreq = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      step();
      if (bus.m_req && !prev_mreq) begin
        order.push_back(bus.m_addr);
        n_mreq++;
      end
      prev_mreq = bus.m_req;
      if (bus.i_done) n_idone++;
      if (bus.d_done) n_ddone++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    chk("cont grants", n_mreq, 4);
    chk("cont i_done count", n_idone, 2);
    chk("cont d_done count", n_ddone, 2);
    for (int g = 0; g < 4; g++)
      chk($sformatf("cont order%0d", g), (g < order.size()) ? order[g] : 8'hXX,
          (g % 2 == 0) ? 8'h40 : 8'h30);
    chk("cont d_rdata", bus.d_rdata, 8'h5A);
    chk("cont i_rdata", bus.i_rdata, 8'h5A);
    chk("cont idle m_req", bus.m_req, 1'b0);

    // Timeout on a load: m_req high exactly 15 cycles, then done+err.
    drv(0, 0, 8'h00, 1, 0, 8'h55, 8'h00, 0, 8'h99);
    n_mreq = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (bus.m_req) n_mreq++;
      if (bus.d_done) begin
        seen = 1'b1;
        chk("to err", bus.err, 1'b1);
        chk("to d_rdata", bus.d_rdata, 8'h5A);
        chk("to i_done", bus.i_done, 1'b0);
      end
    end
    chk("to done seen", seen, 1'b1);
    chk("to m_req cycles", n_mreq, 15);
    bus.d_req = 1'b0;
    step();
    chk("to err pulse", bus.err, 1'b0);
    chk("to d_done pulse", bus.d_done, 1'b0);
    chk("to idle m_req", bus.m_req, 1'b0);

    // Fetch request pulsed while a store is in MEM is never served.
    drv(0, 0, 8'h70, 1, 1, 8'h66, 8'h99, 0, 8'h00);
    step();
    chk("drop m_we", bus.m_we, 1'b1);
    bus.i_req = 1'b1;
    step();
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b1;
    step();
    chk("drop d_done", bus.d_done, 1'b1);
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("drop m_req c%0d", c), bus.m_req, 1'b0);
      chk($sformatf("drop i_done c%0d", c), bus.i_done, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
